banked_reg_file: RTL
====================

Name: banked_reg_file

Overview:
- Parametrised successor to the single-cycle ARM register file.
- Configurable data width, register count and number of read ports.
- Adds a post-reset clear sweep, write-to-read bypass, a link-register write port and a PC-relative read for the PC index.
- Sits between decode (read addresses) and writeback (write/link), and flags PC writes to the fetch stage.

Parameters:
DATA_W, 32, register and data width in bits
NUM_REGS, 16, number of architectural registers (power of two)
ADDR_W, 4, register index width, must equal log2(NUM_REGS)
NUM_READ, 2, number of independent read ports
PC_INDEX, 15, index that maps to the program counter
LINK_INDEX, 14, index written by linkBit
PC_READ_OFFSET, 8, added to oldPCVal when PC_INDEX is read
LINK_OFFSET, 4, added to oldPCVal when the link register is written

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
writeEnable  input  1  write request for writeDestination
writeDestination  input  ADDR_W  write index
writeData  input  DATA_W  write value
linkBit  input  1  write oldPCVal+LINK_OFFSET to LINK_INDEX
oldPCVal  input  DATA_W  current PC of the instruction in flight
readRegs  input  NUM_READ*ADDR_W  packed read indices; port i at bits [i*ADDR_W +: ADDR_W]
readData  output  NUM_READ*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W]
writeToPC  output  1  accepted write targets PC_INDEX
ready  output  1  clear sweep done; writes are accepted

Behaviour:
- Two-state FSM: CLEAR and RUN. The clear counter clrIdx is ADDR_W bits wide.
- Reset (asynchronous, any time, including mid-sweep): state=CLEAR, clrIdx=0, ready=0. writeToPC=0 and readData=0 while in CLEAR.
- CLEAR: each posedge writes 0 to reg[clrIdx] and increments clrIdx. On the posedge that clears index NUM_REGS-1, state becomes RUN and ready=1. ready therefore rises exactly NUM_REGS posedges after reset deasserts.
- CLEAR: writeEnable and linkBit are ignored; no array update other than the sweep.
- RUN: ready stays 1 until the next reset.
- Define wAcc = writeEnable & ready, and lAcc = linkBit & ready.
- Write (RUN, posedge): if wAcc and writeDestination != PC_INDEX, reg[writeDestination] <= writeData.
- PC writes are never stored in the array; the PC lives in fetch.
- Link (RUN, posedge): if lAcc, reg[LINK_INDEX] <= oldPCVal + LINK_OFFSET (mod 2^DATA_W).
- Collision: if wAcc and lAcc both hold and writeDestination == LINK_INDEX, writeData wins.
- writeToPC is combinational: wAcc & (writeDestination == PC_INDEX). It is 0 in CLEAR.
- Reads are combinational on every port independently, with this priority:
  1. state CLEAR -> 0
  2. index == PC_INDEX -> oldPCVal + PC_READ_OFFSET (mod 2^DATA_W)
  3. wAcc and index == writeDestination -> writeData (bypass)
  4. lAcc and index == LINK_INDEX -> oldPCVal + LINK_OFFSET (bypass), unless rule 3 matched
  5. otherwise -> reg[index]
- Multiple ports may read the same index in the same cycle; each returns an identical value.
- Arithmetic wraps silently; there is no overflow flag.
- Internal array is NUM_REGS x DATA_W. It has no per-register reset other than the sweep.

Test Plan:
1. Clear sweep: pulse reset, hold writeEnable=1, writeDestination=3, writeData=32'hFFFFFFFF -> ready=0 for 16 posedges, then 1. Reading r3 afterwards returns 0 (writes during CLEAR dropped).
2. Write/readback and bypass: RUN, write r8=32'hAAAAAAAA with readRegs port0=8 in the same cycle -> port0=AAAAAAAA combinationally. After the edge with writeEnable=0, port0 still reads AAAAAAAA.
3. PC read and writeToPC: oldPCVal=32'h100, port1=15 -> port1=32'h108. writeEnable=1, dest=15 -> writeToPC=1; the array is unchanged (port0 reading r15 shows 32'h108, not writeData).
4. Link and collision: linkBit=1, oldPCVal=32'h200 -> r14=32'h204 next cycle. Then linkBit=1 with write r14=32'hCCCCCCCC in the same cycle -> r14=CCCCCCCC, and the bypass read shows CCCCCCCC.
5. Reset mid-sweep: assert reset after 7 clear cycles -> ready=0 immediately, and clrIdx restarts. ready rises 16 posedges after the second deassertion.
6. Parameter sweep: DATA_W=16, NUM_REGS=8, ADDR_W=3, NUM_READ=3, PC_INDEX=7, LINK_INDEX=6 -> clear takes 8 cycles. oldPCVal=16'hFFFC reads PC as 16'h0004 (wrap). All three ports read r2 after writing 16'h1234 and return 1234.

Source files
------------

// File: rtl/banked_reg_file_if.sv
// Register-file access bus shared by decode (read indices), writeback
// (write/link requests) and fetch (writeToPC).
//   master : drives write/link requests, oldPCVal and read indices
//   slave  : the register file; returns readData, writeToPC, ready
interface banked_reg_file_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_READ = 2
);
  logic                         writeEnable;
  logic [ADDR_W-1:0]            writeDestination;
  logic [DATA_W-1:0]            writeData;
  logic                         linkBit;
  logic [DATA_W-1:0]            oldPCVal;
  logic [NUM_READ*ADDR_W-1:0]   readRegs;
  logic [NUM_READ*DATA_W-1:0]   readData;
  logic                         writeToPC;
  logic                         ready;

  modport master (
    output writeEnable, writeDestination, writeData, linkBit, oldPCVal, readRegs,
    input  readData, writeToPC, ready
  );

  modport slave (
    input  writeEnable, writeDestination, writeData, linkBit, oldPCVal, readRegs,
    output readData, writeToPC, ready
  );
endinterface

// File: rtl/banked_reg_file.sv
// Banked ARM-style register file with post-reset clear sweep, write->read
// and link->read bypass, a link-register write port and PC-relative reads.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, restarts the clear sweep
//   rf    : slave side of banked_reg_file_if (write/link/read/ready/writeToPC)
module banked_reg_file #(
  parameter int DATA_W         = 32,
  parameter int NUM_REGS       = 16,
  parameter int ADDR_W         = 4,
  parameter int NUM_READ       = 2,
  parameter int PC_INDEX       = 15,
  parameter int LINK_INDEX     = 14,
  parameter int PC_READ_OFFSET = 8,
  parameter int LINK_OFFSET    = 4
) (
  input  logic              clk,
  input  logic              reset,
  banked_reg_file_if.slave  rf
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(PC_INDEX);
  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_INDEX);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0]  regs [NUM_REGS];

  logic               w_acc, l_acc;
  logic [DATA_W-1:0]  link_val, pc_val;
  logic [ADDR_W-1:0]  rd_idx;
  logic [DATA_W-1:0]  rd_val;

  assign w_acc    = rf.writeEnable & rf.ready;
  assign l_acc    = rf.linkBit & rf.ready;
  assign link_val = rf.oldPCVal + DATA_W'(LINK_OFFSET);
  assign pc_val   = rf.oldPCVal + DATA_W'(PC_READ_OFFSET);

  // PC lives in fetch: a PC write is only flagged, never stored.
  assign rf.writeToPC = w_acc & (rf.writeDestination == PC_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    rf.ready    = 1'b0;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state_nxt = RUN;
      end
      RUN: rf.ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  // Array has no reset of its own; the sweep zeroes it one entry per cycle.
  // Link is applied before the write so writeData wins a collision on LINK.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[clr_idx] <= '0;
    end else begin
      if (l_acc) regs[LINK_IDX] <= link_val;
      if (w_acc && rf.writeDestination != PC_IDX) regs[rf.writeDestination] <= rf.writeData;
    end
  end

  // Per-port read mux: CLEAR > PC > write bypass > link bypass > array.
  always_comb begin
    rf.readData = '0;
    rd_idx      = '0;
    rd_val      = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      rd_idx = rf.readRegs[i*ADDR_W +: ADDR_W];
      if (state == CLEAR)                                 rd_val = '0;
      else if (rd_idx == PC_IDX)                          rd_val = pc_val;
      else if (w_acc && rd_idx == rf.writeDestination)    rd_val = rf.writeData;
      else if (l_acc && rd_idx == LINK_IDX)               rd_val = link_val;
      else                                                rd_val = regs[rd_idx];
      rf.readData[i*DATA_W +: DATA_W] = rd_val;
    end
  end

endmodule
